umi_rr_arbiter: RTL and testbench

UMI_RR_ARBITER -- requirements
Module: umi_rr_arbiter

---
 rtl/umi_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_umi_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_rr_arbiter.sv
// rtl/umi_rr_arbiter.sv - N-port round-robin UMI arbiter with a single registered output stage
//
// Parameters:
//   N  - number of UMI input ports (2..16)
//   AW - address width
//   CW - command width
//   DW - data width
// Ports:
//   umi_clk          - clock for all logic
//   umi_reset        - synchronous active-high reset
//   umi_in_valid     - per-port request
//   umi_in_cmd       - flattened commands, port i at [i*CW +: CW]
//   umi_in_dstaddr   - flattened destination addresses, port i at [i*AW +: AW]
//   umi_in_srcaddr   - flattened source addresses, port i at [i*AW +: AW]
//   umi_in_data      - flattened data, port i at [i*DW +: DW]
//   umi_in_ready     - per-port accept, one-hot or zero
//   umi_out_valid    - registered output valid
//   umi_out_cmd/dstaddr/srcaddr/data - registered transaction fields
//   umi_out_ready    - downstream accept
//   umi_out_grant    - one-hot index of the port that loaded the output entry

module umi_rr_arbiter #(
    parameter int N  = 4,
    parameter int AW = 64,
    parameter int CW = 32,
    parameter int DW = 256
) (
    input  logic          umi_clk,
    input  logic          umi_reset,
    input  logic [N-1:0]  umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]  umi_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready,
    output logic [N-1:0]  umi_out_grant
);

    localparam int            PW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]   N_EXT = (PW+1)'(N);
    localparam logic [PW-1:0] LAST  = PW'(N-1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          load;
    logic          win_any;
    logic [PW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic [PW:0]   scan_idx;
    logic [CW-1:0] sel_cmd;
    logic [AW-1:0] sel_dstaddr;
    logic [AW-1:0] sel_srcaddr;
    logic [DW-1:0] sel_data;

    // The output register can take a new entry when empty or draining this cycle.
    assign load = ~umi_out_valid | umi_out_ready;

    // Scan ptr, ptr+1, ... modulo N; the first requester wins.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr} + (PW+1)'(k);
            if (scan_idx >= N_EXT) begin
                scan_idx = scan_idx - N_EXT;
            end
            if (!win_any && umi_in_valid[scan_idx[PW-1:0]]) begin
                win_any = 1'b1;
                win_idx = scan_idx[PW-1:0];
            end
        end
        win_oh[win_idx] = win_any;
    end

    // Ready depends on other ports' valids only through winner selection.
    assign umi_in_ready = win_oh & {N{load & ~umi_reset}};

    assign ptr_next = (win_idx == LAST) ? '0 : win_idx + 1'b1;

    always_comb begin
        sel_cmd     = '0;
        sel_dstaddr = '0;
        sel_srcaddr = '0;
        sel_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (win_oh[i]) begin
                sel_cmd     = umi_in_cmd[i*CW +: CW];
                sel_dstaddr = umi_in_dstaddr[i*AW +: AW];
                sel_srcaddr = umi_in_srcaddr[i*AW +: AW];
                sel_data    = umi_in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge umi_clk) begin
        if (umi_reset) begin
            umi_out_valid   <= 1'b0;
            umi_out_cmd     <= '0;
            umi_out_dstaddr <= '0;
            umi_out_srcaddr <= '0;
            umi_out_data    <= '0;
            umi_out_grant   <= '0;
            ptr             <= '0;
        end else if (load) begin
            if (win_any) begin
                umi_out_valid   <= 1'b1;
                umi_out_cmd     <= sel_cmd;
                umi_out_dstaddr <= sel_dstaddr;
                umi_out_srcaddr <= sel_srcaddr;
                umi_out_data    <= sel_data;
                umi_out_grant   <= win_oh;
                ptr             <= ptr_next;
            end else begin
                // Fields and grant keep their last values; only valid drops.
                umi_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// tb/tb_umi_rr_arbiter.sv - directed and scoreboarded checks for umi_rr_arbiter

module tb_umi_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int CW = 8;
    localparam int DW = 32;
    localparam int FW = CW + 2*AW + DW;
    localparam int TOTAL  = 10000;
    localparam int BUDGET = 50000;

    logic            umi_clk = 1'b0;
    logic            umi_reset = 1'b1;
    logic [N-1:0]    umi_in_valid = '0;
    logic [N*CW-1:0] umi_in_cmd = '0;
    logic [N*AW-1:0] umi_in_dstaddr = '0;
    logic [N*AW-1:0] umi_in_srcaddr = '0;
    logic [N*DW-1:0] umi_in_data = '0;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready = 1'b0;
    logic [N-1:0]    umi_out_grant;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [FW-1:0] sb [N][$];

    umi_rr_arbiter #(.N(N), .AW(AW), .CW(CW), .DW(DW)) dut (
        .umi_clk         (umi_clk),
        .umi_reset       (umi_reset),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .umi_out_grant   (umi_out_grant)
    );

    always #5 umi_clk = ~umi_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge umi_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [CW-1:0] c, input logic [AW-1:0] d,
                            input logic [AW-1:0] s, input logic [DW-1:0] x);
        umi_in_cmd[p*CW +: CW]     = c;
        umi_in_dstaddr[p*AW +: AW] = d;
        umi_in_srcaddr[p*AW +: AW] = s;
        umi_in_data[p*DW +: DW]    = x;
    endtask

    function automatic logic [FW-1:0] port_word(input int p);
        return {umi_in_cmd[p*CW +: CW], umi_in_dstaddr[p*AW +: AW],
                umi_in_srcaddr[p*AW +: AW], umi_in_data[p*DW +: DW]};
    endfunction

    initial begin
        logic [N-1:0] exp_g [5];
        int acc_cnt, del_cnt, cyc, acc_port, gidx;
        logic out_fire;
        logic [FW-1:0] acc_word, out_word, exp_word;

        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

        // Reset with every port requesting and downstream ready.
        for (int i = 0; i < N; i++) set_port(i, CW'(8'h20 + i), AW'(16'h100 + i), AW'(16'h200 + i), DW'(32'h1000 + i));
        umi_in_valid  = 4'b1111;
        umi_out_ready = 1'b1;
        umi_reset     = 1'b1;
        #2;
        check("rst_in_ready", umi_in_ready, 4'b0000);
        tick();
        tick();
        check("rst_in_ready2", umi_in_ready, 4'b0000);
        check("rst_out_valid", umi_out_valid, 1'b0);
        check("rst_out_grant", umi_out_grant, 4'b0000);
        check("rst_out_fields", {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data}, '0);

        // All ports requesting: strict rotation starting at port 0.
        umi_reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rot_in_ready", umi_in_ready, exp_g[k]);
            tick();
            check("rot_grant", umi_out_grant, exp_g[k]);
            check("rot_valid", umi_out_valid, 1'b1);
            check("rot_cmd", umi_out_cmd, 8'h20 + (k % 4));
        end

        // Single requester on port 2: one beat per cycle, one cycle latency.
        umi_in_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            set_port(2, CW'(8'h10 + k), AW'(16'h3000 + k), AW'(16'h4000 + k), DW'(32'hC0DE0000 + k));
            #1;
            check("p2_in_ready", umi_in_ready, 4'b0100);
            tick();
            check("p2_valid", umi_out_valid, 1'b1);
            check("p2_cmd", umi_out_cmd, 8'h10 + k);
            check("p2_data", umi_out_data, 32'hC0DE0000 + k);
        end

        // Idle drains the output.
        umi_in_valid = 4'b0000;
        tick();
        check("idle_valid", umi_out_valid, 1'b0);
        check("idle_cmd_hold", umi_out_cmd, 8'h17);

        // Backpressure: entry 0xA5 held for 5 cycles while ports 0 and 1 request.
        set_port(0, 8'hA5, 16'hAAAA, 16'h5555, 32'hA5A5A5A5);
        umi_in_valid = 4'b0001;
        tick();
        check("bp_load_cmd", umi_out_cmd, 8'hA5);
        umi_out_ready = 1'b0;
        set_port(0, 8'h01, 16'h0001, 16'h0001, 32'h1);
        set_port(1, 8'h02, 16'h0002, 16'h0002, 32'h2);
        umi_in_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", umi_in_ready, 4'b0000);
            tick();
            check("bp_valid", umi_out_valid, 1'b1);
            check("bp_cmd", umi_out_cmd, 8'hA5);
            check("bp_grant", umi_out_grant, 4'b0001);
        end
        umi_out_ready = 1'b1;
        #1;
        check("bp_release_ready", umi_in_ready, 4'b0010);
        tick();
        check("bp_release_cmd", umi_out_cmd, 8'h02);
        check("bp_release_grant", umi_out_grant, 4'b0010);

        // Wrap: port 3 last granted, then ports 1 and 3 request.
        set_port(3, 8'h33, 16'h3, 16'h3, 32'h3);
        umi_in_valid = 4'b1000;
        tick();
        check("wrap_pre_grant", umi_out_grant, 4'b1000);
        set_port(1, 8'h11, 16'h1, 16'h1, 32'h11);
        umi_in_valid = 4'b1010;
        #1;
        check("wrap_ready1", umi_in_ready, 4'b0010);
        tick();
        check("wrap_grant1", umi_out_grant, 4'b0010);
        check("wrap_cmd1", umi_out_cmd, 8'h11);
        check("wrap_ready3", umi_in_ready, 4'b1000);
        tick();
        check("wrap_grant3", umi_out_grant, 4'b1000);

        // Reset while an entry is stalled: it is discarded, ptr returns to 0.
        set_port(0, 8'h77, 16'h7, 16'h7, 32'h77);
        umi_in_valid = 4'b0001;
        tick();
        check("mr_load_cmd", umi_out_cmd, 8'h77);
        umi_out_ready = 1'b0;
        umi_in_valid  = 4'b0000;
        umi_reset     = 1'b1;
        tick();
        check("mr_valid", umi_out_valid, 1'b0);
        check("mr_grant", umi_out_grant, 4'b0000);
        check("mr_cmd", umi_out_cmd, 8'h00);
        umi_reset     = 1'b0;
        umi_out_ready = 1'b1;
        tick();
        check("mr_no_replay", umi_out_valid, 1'b0);
        umi_in_valid = 4'b1111;
        #1;
        check("mr_ptr0_ready", umi_in_ready, 4'b0001);
        tick();
        check("mr_ptr0_grant", umi_out_grant, 4'b0001);
        umi_in_valid = 4'b0000;
        tick();
        check("mr_drain", umi_out_valid, 1'b0);

        // Random valid/ready with a per-port scoreboard.
        acc_cnt = 0;
        del_cnt = 0;
        cyc     = 0;
        while ((acc_cnt < TOTAL || del_cnt < acc_cnt || umi_in_valid != 0) && cyc < BUDGET) begin
            umi_out_ready = ($urandom_range(3) != 0);
            #1;
            acc_port = -1;
            acc_word = '0;
            for (int i = 0; i < N; i++) begin
                if (umi_in_ready[i] && umi_in_valid[i]) begin
                    acc_port = i;
                    acc_word = port_word(i);
                end
            end
            check("rnd_ready_onehot", ($countones(umi_in_ready) <= 1), 1'b1);
            out_fire = umi_out_valid && umi_out_ready;
            out_word = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
            gidx = -1;
            for (int i = 0; i < N; i++) if (umi_out_grant == N'(1 << i)) gidx = i;
            tick();
            cyc++;
            if (out_fire) begin
                check("rnd_grant_onehot", (gidx >= 0), 1'b1);
                if (gidx >= 0) begin
                    check("rnd_sb_nonempty", (sb[gidx].size() > 0), 1'b1);
                    if (sb[gidx].size() > 0) begin
                        exp_word = sb[gidx].pop_front();
                        check("rnd_fields", out_word, exp_word);
                    end
                end
                del_cnt++;
            end
            if (acc_port >= 0) begin
                sb[acc_port].push_back(acc_word);
                acc_cnt++;
                umi_in_valid[acc_port] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!umi_in_valid[i] && acc_cnt < TOTAL && $urandom_range(1) == 1) begin
                    set_port(i, CW'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
                    umi_in_valid[i] = 1'b1;
                end
            end
        end
        check("rnd_no_timeout", (cyc < BUDGET), 1'b1);
        check("rnd_count", del_cnt, acc_cnt);
        for (int i = 0; i < N; i++) check("rnd_sb_empty", sb[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
